fir_filter_stream: RTL and testbench

- Parametrised streaming FIR filter: NUM_TAPS-tap direct-form delay line with a valid handshake.
- Coefficients are held in a runtime-writable register bank.
- Each output is rounded, shifted and saturated to a fixed-point width.
- Sits between sample source and downstream DSP; coefficients are written by the control block at any time.

---
 rtl/fir_pkg.sv | 38 +++
 rtl/fir_round_sat.sv | 73 +++++++
 rtl/fir_filter_stream.sv | 124 ++++++++++++
 tb/tb_fir_filter_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared sizing and saturation helpers for the FIR block family.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // Saturation bounds are evaluated in a fixed 64-bit signed domain.
    localparam int c_SAT_CALC_WIDTH = 64;

    typedef struct packed {
        logic signed [c_SAT_CALC_WIDTH-1:0] min_val;
        logic signed [c_SAT_CALC_WIDTH-1:0] max_val;
    } sat_limits_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; (1 << i) < value; i++) begin
            result = i + 1;
        end
        return result;
    endfunction

    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + clog2(taps);
    endfunction

    function automatic sat_limits_t sat_limits(input int width);
        sat_limits_t lim;
        lim.max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
        lim.min_val = -(64'sd1 <<< (width - 1));
        return lim;
    endfunction

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : fir_round_sat
// Brief    : Registered round-half-up, arithmetic shift and signed saturation.
// Revision : 1.0 - initial release
// ============================================================================
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_WIDTH = 35,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SHIFT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        sat_out
);

    // One guard bit so the rounding increment can never wrap.
    localparam int          c_EXT_WIDTH = ACC_WIDTH + 1;
    localparam sat_limits_t c_LIM       = sat_limits(OUT_WIDTH);
    localparam logic signed [c_SAT_CALC_WIDTH-1:0] c_MAX = c_LIM.max_val;
    localparam logic signed [c_SAT_CALC_WIDTH-1:0] c_MIN = c_LIM.min_val;

    logic signed [c_EXT_WIDTH-1:0]      w_ext;
    logic signed [c_EXT_WIDTH-1:0]      w_scaled;
    logic signed [c_SAT_CALC_WIDTH-1:0] w_wide;
    logic signed [OUT_WIDTH-1:0]        w_clamped;
    logic                               w_sat;

    assign w_ext = c_EXT_WIDTH'(acc_in);

    if (OUT_SHIFT > 0) begin : g_round
        localparam logic signed [c_EXT_WIDTH-1:0] c_HALF = c_EXT_WIDTH'(1) <<< (OUT_SHIFT - 1);
        assign w_scaled = (w_ext + c_HALF) >>> OUT_SHIFT;
    end else begin : g_passthru
        assign w_scaled = w_ext;
    end

    assign w_wide = c_SAT_CALC_WIDTH'(w_scaled);

    always_comb begin
        w_clamped = OUT_WIDTH'(w_wide);
        w_sat     = 1'b0;
        if (w_wide > c_MAX) begin
            w_clamped = OUT_WIDTH'(c_MAX);
            w_sat     = 1'b1;
        end else if (w_wide < c_MIN) begin
            w_clamped = OUT_WIDTH'(c_MIN);
            w_sat     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sat_out   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= w_clamped;
                sat_out  <= w_sat;
            end
        end
    end

endmodule : fir_round_sat
`default_nettype wire

// File: rtl/fir_filter_stream.sv
`default_nettype none
// ============================================================================
// Module   : fir_filter_stream
// Brief    : Streaming direct-form FIR with writable coefficients, 3-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module fir_filter_stream
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int NUM_TAPS    = 8,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_SHIFT   = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [DATA_WIDTH-1:0]  samples_in,
    input  logic                          flush,
    input  logic                          coeff_wr_en,
    input  logic [clog2(NUM_TAPS)-1:0]    coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data,
    output logic                          out_valid,
    output logic signed [OUT_WIDTH-1:0]   filter_out,
    output logic                          out_sat
);

    localparam int c_ADDR_WIDTH = clog2(NUM_TAPS);
    localparam int c_PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam int c_ACC_WIDTH  = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);

    logic [NUM_TAPS-2:0][DATA_WIDTH-1:0]   w_taps;
    logic [NUM_TAPS-1:0][c_PROD_WIDTH-1:0] w_prods;
    logic signed [c_ACC_WIDTH-1:0]         w_sum;
    logic signed [c_ACC_WIDTH-1:0]         r_sum;
    logic                                  r_tap_valid;
    logic                                  r_prod_valid;
    logic                                  r_sum_valid;

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic signed [DATA_WIDTH-1:0]   r_tap;
        logic signed [COEFF_WIDTH-1:0]  r_coeff;
        logic signed [c_PROD_WIDTH-1:0] r_prod;
        logic signed [DATA_WIDTH-1:0]   w_tap_next;

        // Flush zeroes the history; tap 0 still captures a sample arriving on the same edge.
        if (k == 0) begin : g_head
            assign w_tap_next = in_valid ? samples_in : '0;
        end else begin : g_body
            assign w_tap_next = flush ? '0 : w_taps[k-1];
        end

        if (k < NUM_TAPS - 1) begin : g_fwd
            assign w_taps[k] = r_tap;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_tap <= '0;
            end else if (in_valid || flush) begin
                r_tap <= w_tap_next;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_coeff <= '0;
            end else if (coeff_wr_en && (coeff_addr == c_ADDR_WIDTH'(k))) begin
                r_coeff <= coeff_data;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_prod <= '0;
            end else if (r_tap_valid) begin
                r_prod <= c_PROD_WIDTH'(r_tap) * c_PROD_WIDTH'(r_coeff);
            end
        end

        assign w_prods[k] = r_prod;
    end

    // Accumulator carries clog2(NUM_TAPS) growth bits, so the sum cannot overflow.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_sum = w_sum + c_ACC_WIDTH'($signed(w_prods[k]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tap_valid  <= 1'b0;
            r_prod_valid <= 1'b0;
            r_sum_valid  <= 1'b0;
            r_sum        <= '0;
        end else begin
            r_tap_valid  <= in_valid;
            r_prod_valid <= r_tap_valid;
            r_sum_valid  <= r_prod_valid;
            if (r_prod_valid) begin
                r_sum <= w_sum;
            end
        end
    end

    fir_round_sat #(
        .ACC_WIDTH (c_ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_round_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r_sum_valid),
        .acc_in    (r_sum),
        .out_valid (out_valid),
        .data_out  (filter_out),
        .sat_out   (out_sat)
    );

endmodule : fir_filter_stream
`default_nettype wire

// File: tb/tb_fir_filter_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fir_filter_stream
// Brief    : Randomised and directed bench for two FIR configurations against a dot-product model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_filter_stream;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               in_valid;
    logic signed [15:0] samples_in;
    logic               flush;
    logic               coeff_wr_en;
    logic [2:0]         coeff_addr;
    logic signed [15:0] coeff_data;

    logic               a_valid, a_sat, b_valid, b_sat;
    logic signed [15:0] a_out;
    logic signed [39:0] b_out;

    fir_filter_stream dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .samples_in(samples_in),
        .flush(flush), .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr),
        .coeff_data(coeff_data), .out_valid(a_valid), .filter_out(a_out), .out_sat(a_sat)
    );

    fir_filter_stream #(.OUT_WIDTH(40), .OUT_SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .samples_in(samples_in),
        .flush(flush), .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr),
        .coeff_data(coeff_data), .out_valid(b_valid), .filter_out(b_out), .out_sat(b_sat)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: output = dot product of the accepted-sample history with the coefficients.
    typedef struct {
        bit     v;
        longint a;
        bit     sa;
        longint b;
        bit     sb;
    } exp_t;

    exp_t   pipe[$];
    longint hist[$];
    longint m_coeffs[N];
    longint last_a = 0;
    longint last_b = 0;

    function automatic void scale(input longint acc, input int shift, input int width,
                                  output longint val, output bit sat);
        longint r, hi, lo;
        r = acc;
        if (shift > 0) r = (r + (longint'(1) <<< (shift - 1))) >>> shift;
        hi  = (longint'(1) <<< (width - 1)) - 1;
        lo  = -hi - 1;
        val = r;
        sat = 1'b0;
        if (r > hi) begin
            val = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            val = lo;
            sat = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        exp_t   e;
        longint acc;
        e = '{default: 0};
        if (!reset) begin
            foreach (m_coeffs[k]) m_coeffs[k] = 0;
            hist.delete();
            pipe.delete();
            repeat (3) pipe.push_back(e);
            last_a = 0;
            last_b = 0;
        end else begin
            if (coeff_wr_en) m_coeffs[coeff_addr] = longint'(coeff_data);
            if (flush) hist.delete();
            if (in_valid) begin
                hist.push_front(longint'(samples_in));
                if (hist.size() > N) void'(hist.pop_back());
                acc = 0;
                foreach (hist[i]) acc += hist[i] * m_coeffs[i];
                e.v = 1'b1;
                scale(acc, 15, 16, e.a, e.sa);
                scale(acc, 0, 40, e.b, e.sb);
            end
        end
        pipe.push_back(e);
        #1;
        e = pipe.pop_front();
        if (e.v) begin
            last_a = e.a;
            last_b = e.b;
        end
        check("a_valid", a_valid, e.v);
        check("b_valid", b_valid, e.v);
        check("a_out", a_out, last_a);
        check("b_out", b_out, last_b);
        if (e.v) begin
            check("a_sat", a_sat, e.sa);
            check("b_sat", b_sat, e.sb);
        end
    end

    task automatic drive(input bit v, input longint s, input bit fl = 1'b0,
                         input bit we = 1'b0, input int addr = 0, input longint d = 0);
        @(negedge clk);
        in_valid    = v;
        samples_in  = 16'(s);
        flush       = fl;
        coeff_wr_en = we;
        coeff_addr  = 3'(addr);
        coeff_data  = 16'(d);
    endtask

    bit     gv[5] = '{1, 0, 0, 1, 1};
    longint gs[5] = '{10, 7, 7, 20, 30};
    longint ge[5] = '{10, 0, 0, 40, 100};

    initial begin
        reset = 1'b0; in_valid = 1'b0; samples_in = '0; flush = 1'b0;
        coeff_wr_en = 1'b0; coeff_addr = '0; coeff_data = '0;
        repeat (3) @(negedge clk);
        check("reset_a_valid", a_valid, 0);
        check("reset_a_out", a_out, 0);
        check("reset_a_sat", a_sat, 0);
        check("reset_b_out", b_out, 0);
        reset = 1'b1;

        // Impulse through the unscaled 40-bit instance.
        for (int k = 0; k < N; k++) drive(0, 0, 0, 1, k, k + 1);
        drive(1, 100);
        for (int i = 1; i <= 13; i++) begin
            drive(1, 0);
            if (i >= 4 && i <= 11) begin
                check("imp_valid", b_valid, 1);
                check("imp_out", b_out, 100 * (i - 3));
                check("imp_sat", b_sat, 0);
            end else if (i == 12) begin
                check("imp_tail", b_out, 0);
            end
        end

        // Valid gaps: outputs follow the in_valid pattern three edges later.
        for (int j = 0; j < 9; j++) begin
            if (j < 5) drive(gv[j], gs[j], j == 0);
            else       drive(0, 0);
            if (j >= 4) begin
                check("gap_valid", b_valid, gv[j-4]);
                if (gv[j-4]) check("gap_out", b_out, ge[j-4]);
            end
        end

        // Saturation in both directions on the Q15 instance.
        for (int k = 0; k < N; k++) drive(0, 0, 0, 1, k, 32767);
        repeat (14) drive(1, 32767);
        check("sat_pos_out", a_out, 32767);
        check("sat_pos_flag", a_sat, 1);
        repeat (14) drive(1, -32768);
        check("sat_neg_out", a_out, -32768);
        check("sat_neg_flag", a_sat, 1);

        // Round half toward +inf.
        for (int k = 0; k < N; k++) drive(0, 0, 0, 1, k, (k == 0) ? 16384 : 0);
        repeat (6) drive(1, 3);
        check("round_pos", a_out, 2);
        check("round_pos_sat", a_sat, 0);
        repeat (6) drive(1, -3);
        check("round_neg", a_out, -1);

        // Simultaneous flush, sample and coefficient write.
        for (int k = 0; k < N; k++) drive(0, 0, 0, 1, k, 2048);
        repeat (12) drive(1, 1000);
        drive(1, 2000, 1, 1, 0, 4096);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1000);
            if (i <= 3) check("flush_prev", a_out, 500);
            else        check("flush_out", a_out, 250);
        end

        // Mid-stream reset with samples in flight.
        repeat (4) drive(1, 1234);
        @(negedge clk);
        check("pre_reset_valid", a_valid, 1);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("rst_a_valid", a_valid, 0);
        check("rst_a_out", a_out, 0);
        check("rst_a_sat", a_sat, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_out", b_out, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, longint'($urandom_range(0, 65535)) - 32768);
            if (i >= 4) begin
                check("post_rst_a", a_out, 0);
                check("post_rst_b", b_out, 0);
            end
        end

        // Randomised traffic with concurrent writes and occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            longint s;
            s = longint'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 7) == 0) s = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
            drive($urandom_range(0, 3) != 0, s, $urandom_range(0, 63) == 0,
                  $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)),
                  longint'($urandom_range(0, 65535)) - 32768);
        end

        repeat (6) drive(0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fir_filter_stream
`default_nettype wire
